cci_mem_responder: RTL and testbench

Host-side CCI-P memory responder: the FIU end of the channel-0 read and channel-1 write request traffic that the AFU logic issues. Accepts single-line read and write requests, queues them, services them against an on-chip line memory mapped at a programmable line-address window, and returns read responses and write acknowledgements carrying the request mdata. Provides almost-full backpressure on both request channels. Used as a synthesizable host-memory stand-in for AFU bring-up and emulation.

---
 rtl/cci_mem_responder_if.sv | 33 +++
 rtl/cci_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_cci_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cci_mem_responder_if.sv
// CCI-P channel-0 read and channel-1 write request/response bundle between AFU (master) and host responder (slave).
// Pure wiring; requests carry no ready, backpressure is the per-channel almost-full level.
interface cci_mem_responder_if;
   logic         c0_req_valid;
   logic [41:0]  c0_req_addr;
   logic [15:0]  c0_req_mdata;
   logic         c0_alm_full;
   logic         c0_rsp_valid;
   logic [511:0] c0_rsp_data;
   logic [15:0]  c0_rsp_mdata;

   logic         c1_req_valid;
   logic [41:0]  c1_req_addr;
   logic [511:0] c1_req_data;
   logic [15:0]  c1_req_mdata;
   logic         c1_alm_full;
   logic         c1_rsp_valid;
   logic [15:0]  c1_rsp_mdata;

   modport master (
      output c0_req_valid, c0_req_addr, c0_req_mdata,
      output c1_req_valid, c1_req_addr, c1_req_data, c1_req_mdata,
      input  c0_alm_full, c0_rsp_valid, c0_rsp_data, c0_rsp_mdata,
      input  c1_alm_full, c1_rsp_valid, c1_rsp_mdata
   );

   modport slave (
      input  c0_req_valid, c0_req_addr, c0_req_mdata,
      input  c1_req_valid, c1_req_addr, c1_req_data, c1_req_mdata,
      output c0_alm_full, c0_rsp_valid, c0_rsp_data, c0_rsp_mdata,
      output c1_alm_full, c1_rsp_valid, c1_rsp_mdata
   );
endinterface

// File: rtl/cci_mem_responder.sv
// CCI-P host-memory stand-in: queued single-line reads/writes against a windowed line RAM, response 2 cycles after request.
// Backpressure: almost-full per channel from registered occupancy; a push into a full queue is dropped and flags ovf_err.
module cci_mem_responder #(
   parameter int MEM_ADDR_BITS  = 10,
   parameter int FIFO_DEPTH     = 8,
   parameter int ALM_FULL_SLACK = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [41:0]        base_line,
   input  logic               hold,
   cci_mem_responder_if.slave cci,
   output logic [31:0]        rd_count,
   output logic [31:0]        wr_count,
   output logic [15:0]        oob_count,
   output logic               ovf_err
);

   localparam int PW        = $clog2(FIFO_DEPTH);
   localparam int CW        = PW + 1;
   localparam int MEM_LINES = 1 << MEM_ADDR_BITS;
   localparam logic [CW-1:0] Q_FULL     = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ALM_THRESH = CW'(FIFO_DEPTH - ALM_FULL_SLACK);

   typedef struct packed {
      logic [41:0] addr;
      logic [15:0] mdata;
   } rd_hdr_t;

   typedef struct packed {
      logic [41:0]  addr;
      logic [511:0] data;
      logic [15:0]  mdata;
   } wr_hdr_t;

   // Read request queue
   rd_hdr_t       rdq_mem_q [FIFO_DEPTH];
   rd_hdr_t       rdq_head;
   logic [PW-1:0] rdq_wp_q, rdq_wp_d, rdq_rp_q, rdq_rp_d;
   logic [CW-1:0] rdq_cnt_q, rdq_cnt_d;
   logic          rdq_push_ok, rdq_drop, rd_pop_vld;

   // Write request queue
   wr_hdr_t       wrq_mem_q [FIFO_DEPTH];
   wr_hdr_t       wrq_head;
   logic [PW-1:0] wrq_wp_q, wrq_wp_d, wrq_rp_q, wrq_rp_d;
   logic [CW-1:0] wrq_cnt_q, wrq_cnt_d;
   logic          wrq_push_ok, wrq_drop, wr_pop_vld;

   logic [41:0]              rd_idx, wr_idx;
   logic                     rd_inwin, wr_inwin;
   logic [MEM_ADDR_BITS-1:0] rd_line, wr_line;
   logic [511:0]             mem [MEM_LINES];

   logic         c0_vld_q, c0_vld_d, c1_vld_q, c1_vld_d;
   logic [15:0]  c0_md_q, c0_md_d, c1_md_q, c1_md_d;
   logic [511:0] c0_data_q;
   logic [31:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [15:0]  oob_q, oob_d;
   logic [16:0]  oob_sum;
   logic         ovf_q, ovf_d;

   // A full queue rejects the push even when it pops in the same cycle.
   assign rdq_drop    = cci.c0_req_valid && (rdq_cnt_q == Q_FULL);
   assign rdq_push_ok = cci.c0_req_valid && (rdq_cnt_q != Q_FULL);
   assign rd_pop_vld  = !hold && (rdq_cnt_q != '0);
   assign rdq_head    = rdq_mem_q[rdq_rp_q];

   assign wrq_drop    = cci.c1_req_valid && (wrq_cnt_q == Q_FULL);
   assign wrq_push_ok = cci.c1_req_valid && (wrq_cnt_q != Q_FULL);
   assign wr_pop_vld  = !hold && (wrq_cnt_q != '0);
   assign wrq_head    = wrq_mem_q[wrq_rp_q];

   assign rd_idx   = rdq_head.addr - base_line;
   assign wr_idx   = wrq_head.addr - base_line;
   assign rd_inwin = (rd_idx[41:MEM_ADDR_BITS] == '0);
   assign wr_inwin = (wr_idx[41:MEM_ADDR_BITS] == '0);
   assign rd_line  = rd_idx[MEM_ADDR_BITS-1:0];
   assign wr_line  = wr_idx[MEM_ADDR_BITS-1:0];

   always_ff @(posedge clk) begin
      if (rdq_push_ok) rdq_mem_q[rdq_wp_q] <= {cci.c0_req_addr, cci.c0_req_mdata};
      if (wrq_push_ok) wrq_mem_q[wrq_wp_q] <= {cci.c1_req_addr, cci.c1_req_data, cci.c1_req_mdata};
   end

   always_ff @(posedge clk) begin
      if (wr_pop_vld && wr_inwin) mem[wr_line] <= wrq_head.data;
   end

   always_comb begin
      rdq_wp_d  = rdq_wp_q + PW'(rdq_push_ok);
      rdq_rp_d  = rdq_rp_q + PW'(rd_pop_vld);
      rdq_cnt_d = rdq_cnt_q + CW'(rdq_push_ok) - CW'(rd_pop_vld);
      wrq_wp_d  = wrq_wp_q + PW'(wrq_push_ok);
      wrq_rp_d  = wrq_rp_q + PW'(wr_pop_vld);
      wrq_cnt_d = wrq_cnt_q + CW'(wrq_push_ok) - CW'(wr_pop_vld);

      c0_vld_d = rd_pop_vld;
      c0_md_d  = rd_pop_vld ? rdq_head.mdata : c0_md_q;
      c1_vld_d = wr_pop_vld;
      c1_md_d  = wr_pop_vld ? wrq_head.mdata : c1_md_q;

      rd_cnt_d = rd_cnt_q + 32'(c0_vld_q);
      wr_cnt_d = wr_cnt_q + 32'(c1_vld_q);
      oob_sum  = {1'b0, oob_q} + 17'(rd_pop_vld && !rd_inwin) + 17'(wr_pop_vld && !wr_inwin);
      oob_d    = oob_sum[16] ? 16'hFFFF : oob_sum[15:0];
      ovf_d    = ovf_q || rdq_drop || wrq_drop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdq_wp_q  <= '0;
         rdq_rp_q  <= '0;
         rdq_cnt_q <= '0;
         wrq_wp_q  <= '0;
         wrq_rp_q  <= '0;
         wrq_cnt_q <= '0;
         c0_vld_q  <= 1'b0;
         c0_md_q   <= '0;
         c1_vld_q  <= 1'b0;
         c1_md_q   <= '0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         oob_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         rdq_wp_q  <= rdq_wp_d;
         rdq_rp_q  <= rdq_rp_d;
         rdq_cnt_q <= rdq_cnt_d;
         wrq_wp_q  <= wrq_wp_d;
         wrq_rp_q  <= wrq_rp_d;
         wrq_cnt_q <= wrq_cnt_d;
         c0_vld_q  <= c0_vld_d;
         c0_md_q   <= c0_md_d;
         c1_vld_q  <= c1_vld_d;
         c1_md_q   <= c1_md_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         oob_q     <= oob_d;
         ovf_q     <= ovf_d;
      end
   end

   // Registered RAM read samples the pre-write contents, so a same-cycle write to the line is read-first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c0_data_q <= '0;
      end else if (rd_pop_vld) begin
         c0_data_q <= rd_inwin ? mem[rd_line] : '0;
      end
   end

   assign cci.c0_alm_full  = (rdq_cnt_q >= ALM_THRESH);
   assign cci.c1_alm_full  = (wrq_cnt_q >= ALM_THRESH);
   assign cci.c0_rsp_valid = c0_vld_q;
   assign cci.c0_rsp_data  = c0_data_q;
   assign cci.c0_rsp_mdata = c0_md_q;
   assign cci.c1_rsp_valid = c1_vld_q;
   assign cci.c1_rsp_mdata = c1_md_q;

   assign rd_count  = rd_cnt_q;
   assign wr_count  = wr_cnt_q;
   assign oob_count = oob_q;
   assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_cci_mem_responder.sv
// Self-checking bench for cci_mem_responder: vector table, directed corner sequences, randomized traffic vs. a queue model.
module tb_cci_mem_responder;
   localparam logic [41:0] BASE = 42'h1_2345_6000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [41:0] base_line;
   logic        hold;
   logic [31:0] rd_count, wr_count;
   logic [15:0] oob_count;
   logic        ovf_err;

   cci_mem_responder_if bus();

   cci_mem_responder #(.MEM_ADDR_BITS(10), .FIFO_DEPTH(8), .ALM_FULL_SLACK(4)) dut (
      .clk(clk), .rst_n(rst_n), .base_line(base_line), .hold(hold), .cci(bus),
      .rd_count(rd_count), .wr_count(wr_count), .oob_count(oob_count), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int t; logic [15:0] md; logic [511:0] dat; } rsp_t;
   rsp_t rd_log[$], wr_log[$], rd_exp[$], wr_exp[$];

   always @(negedge clk) begin
      if (bus.c0_rsp_valid === 1'b1) rd_log.push_back(rsp_t'{t: cyc, md: bus.c0_rsp_mdata, dat: bus.c0_rsp_data});
      if (bus.c1_rsp_valid === 1'b1) wr_log.push_back(rsp_t'{t: cyc, md: bus.c1_rsp_mdata, dat: '0});
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.c0_req_valid = 1'b0; bus.c0_req_addr = '0; bus.c0_req_mdata = '0;
      bus.c1_req_valid = 1'b0; bus.c1_req_addr = '0; bus.c1_req_data = '0; bus.c1_req_mdata = '0;
   endtask

   task automatic set_rd(input logic [41:0] a, input logic [15:0] md);
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = a; bus.c0_req_mdata = md;
   endtask

   task automatic set_wr(input logic [41:0] a, input logic [511:0] d, input logic [15:0] md);
      bus.c1_req_valid = 1'b1; bus.c1_req_addr = a; bus.c1_req_data = d; bus.c1_req_mdata = md;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   function automatic logic [41:0] la(input int off);
      return BASE + 42'(off);
   endfunction

   function automatic logic [511:0] fill(input logic [7:0] b);
      return {64{b}};
   endfunction

   function automatic logic [511:0] rand_line();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic int pick_off();
      int r = int'($urandom_range(0, 19));
      if (r == 0) return -1 - int'($urandom_range(0, 5));
      if (r == 1) return 1024 + int'($urandom_range(0, 100));
      return int'($urandom_range(0, 7));
   endfunction

   typedef struct {
      bit          wr;
      int          off;
      logic [7:0]  dat;
      logic [15:0] md;
      logic [7:0]  exp_dat;
      logic [15:0] exp_oob;
   } vec_t;

   vec_t         vt[9];
   logic [511:0] mdl[64];

   initial begin
      int           t0, off, n_oob, alm_hits, nr, nw;
      logic [511:0] d;
      logic [15:0]  md;
      bit           inwin;

      rst_n = 1'b0; hold = 1'b0; base_line = BASE;
      clr();

      vt[0] = '{1'b1,    0, 8'h5A, 16'd1,  8'h00, 16'd0};
      vt[1] = '{1'b1,    3, 8'hA5, 16'd7,  8'h00, 16'd0};
      vt[2] = '{1'b0,    3, 8'h00, 16'd9,  8'hA5, 16'd0};
      vt[3] = '{1'b0,   -1, 8'h00, 16'd10, 8'h00, 16'd1};
      vt[4] = '{1'b1, 1024, 8'h3C, 16'd11, 8'h00, 16'd2};
      vt[5] = '{1'b0,    0, 8'h00, 16'd12, 8'h5A, 16'd2};
      vt[6] = '{1'b1, 1023, 8'hC3, 16'd13, 8'h00, 16'd2};
      vt[7] = '{1'b0, 1023, 8'h00, 16'd14, 8'hC3, 16'd2};
      vt[8] = '{1'b0, 1024, 8'h00, 16'd15, 8'h00, 16'd3};

      step(3);
      chk("rst c0_rsp_valid", bus.c0_rsp_valid, 0);
      chk("rst c1_rsp_valid", bus.c1_rsp_valid, 0);
      chk("rst c0_rsp_data", bus.c0_rsp_data, 0);
      chk("rst c0_alm_full", bus.c0_alm_full, 0);
      chk("rst c1_alm_full", bus.c1_alm_full, 0);
      chk("rst rd_count", rd_count, 0);
      chk("rst wr_count", wr_count, 0);
      chk("rst oob_count", oob_count, 0);
      chk("rst ovf_err", ovf_err, 0);
      rst_n = 1'b1;
      step(1);

      for (int i = 0; i < 9; i++) begin
         rd_log.delete(); wr_log.delete();
         t0 = cyc;
         if (vt[i].wr) set_wr(la(vt[i].off), fill(vt[i].dat), vt[i].md);
         else set_rd(la(vt[i].off), vt[i].md);
         step(1);
         clr();
         step(4);
         if (vt[i].wr) begin
            chk($sformatf("vec%0d ack count", i), wr_log.size(), 1);
            if (wr_log.size() > 0) begin
               chk($sformatf("vec%0d ack latency", i), wr_log[0].t - t0, 2);
               chk($sformatf("vec%0d ack mdata", i), wr_log[0].md, vt[i].md);
            end
         end else begin
            chk($sformatf("vec%0d rsp count", i), rd_log.size(), 1);
            if (rd_log.size() > 0) begin
               chk($sformatf("vec%0d rsp latency", i), rd_log[0].t - t0, 2);
               chk($sformatf("vec%0d rsp mdata", i), rd_log[0].md, vt[i].md);
               chk($sformatf("vec%0d rsp data", i), rd_log[0].dat, fill(vt[i].exp_dat));
            end
         end
         chk($sformatf("vec%0d oob_count", i), oob_count, vt[i].exp_oob);
      end
      chk("table wr_count", wr_count, 4);
      chk("table rd_count", rd_count, 5);
      chk("table ovf_err", ovf_err, 0);

      // Backpressure on both channels with the queues held.
      do_reset();
      rd_log.delete(); wr_log.delete();
      hold = 1'b1;
      for (int i = 0; i < 9; i++) begin
         set_rd(la((i % 2) ? 3 : 0), 16'(100 + i));
         set_wr(la(2000), fill(8'hEE), 16'(200 + i));
         step(1);
         clr();
         chk($sformatf("bp push%0d c0_alm_full", i + 1), bus.c0_alm_full, (i + 1 >= 4));
         chk($sformatf("bp push%0d c1_alm_full", i + 1), bus.c1_alm_full, (i + 1 >= 4));
         chk($sformatf("bp push%0d ovf_err", i + 1), ovf_err, (i == 8));
      end
      chk("bp no rsp under hold", rd_log.size() + wr_log.size(), 0);
      hold = 1'b0;
      step(14);
      chk("bp rd rsp count", rd_log.size(), 8);
      chk("bp wr ack count", wr_log.size(), 8);
      for (int i = 0; i < 8 && i < rd_log.size(); i++) begin
         chk($sformatf("bp rd%0d mdata", i), rd_log[i].md, 16'(100 + i));
         chk($sformatf("bp rd%0d data", i), rd_log[i].dat, fill((i % 2) ? 8'hA5 : 8'h5A));
         chk($sformatf("bp rd%0d back-to-back", i), rd_log[i].t - rd_log[0].t, i);
      end
      for (int i = 0; i < 8 && i < wr_log.size(); i++)
         chk($sformatf("bp wr%0d mdata", i), wr_log[i].md, 16'(200 + i));
      chk("bp rd_count", rd_count, 8);
      chk("bp wr_count", wr_count, 8);
      chk("bp oob_count", oob_count, 8);
      chk("bp ovf_err sticky", ovf_err, 1);
      chk("bp alm_full drained", bus.c0_alm_full, 0);

      // Same-cycle read/write collision is read-first; a write is visible to the next cycle's read.
      do_reset();
      set_wr(la(5), fill(8'h11), 16'd30); step(1); clr(); step(3);
      hold = 1'b1;
      set_rd(la(5), 16'd31); set_wr(la(5), fill(8'h22), 16'd32);
      step(1); clr(); step(1);
      rd_log.delete();
      hold = 1'b0;
      step(4);
      chk("coll rsp count", rd_log.size(), 1);
      if (rd_log.size() > 0) chk("coll read-first data", rd_log[0].dat, fill(8'h11));
      rd_log.delete();
      set_rd(la(5), 16'd33); step(1); clr(); step(3);
      if (rd_log.size() > 0) chk("coll later read data", rd_log[0].dat, fill(8'h22));
      else chk("coll later read count", rd_log.size(), 1);
      rd_log.delete();
      set_wr(la(6), fill(8'h33), 16'd34); step(1); clr();
      set_rd(la(6), 16'd35); step(1); clr(); step(3);
      if (rd_log.size() > 0) chk("wr-then-rd next cycle data", rd_log[0].dat, fill(8'h33));
      else chk("wr-then-rd count", rd_log.size(), 1);

      // Reset mid-flight discards queued reads.
      set_wr(la(2), fill(8'h77), 16'd36); step(1); clr(); step(3);
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_rd(la(2), 16'(40 + i)); step(1); clr();
      end
      chk("midrst alm_full before", bus.c0_alm_full, 1);
      rd_log.delete(); wr_log.delete();
      rst_n = 1'b0; step(1); rst_n = 1'b1;
      hold = 1'b0;
      step(6);
      chk("midrst no rsp", rd_log.size(), 0);
      chk("midrst rd_count", rd_count, 0);
      chk("midrst wr_count", wr_count, 0);
      chk("midrst alm_full", bus.c0_alm_full, 0);
      set_rd(la(2), 16'd50); step(1); clr(); step(3);
      if (rd_log.size() > 0) chk("midrst memory kept", rd_log[0].dat, fill(8'h77));
      else chk("midrst post read count", rd_log.size(), 1);

      // Streaming plus randomized traffic against the model.
      do_reset();
      rd_log.delete(); wr_log.delete(); rd_exp.delete(); wr_exp.delete();
      n_oob = 0; alm_hits = 0;
      for (int i = 0; i < 64; i++) begin
         d = rand_line();
         mdl[i] = d;
         wr_exp.push_back(rsp_t'{t: cyc + 2, md: 16'(i), dat: '0});
         set_wr(la(i), d, 16'(i));
         step(1);
         if (bus.c0_alm_full || bus.c1_alm_full) alm_hits++;
      end
      clr();
      for (int i = 0; i < 64; i++) begin
         rd_exp.push_back(rsp_t'{t: cyc + 2, md: 16'(i), dat: mdl[i]});
         set_rd(la(i), 16'(i));
         step(1);
         if (bus.c0_alm_full || bus.c1_alm_full) alm_hits++;
      end
      clr();
      step(3);
      chk("stream alm_full stayed low", alm_hits, 0);
      for (int i = 0; i < 300; i++) begin
         clr();
         if ($urandom_range(0, 1) == 1) begin
            off = pick_off();
            md = 16'($urandom);
            inwin = (off >= 0 && off < 1024);
            rd_exp.push_back(rsp_t'{t: cyc + 2, md: md, dat: inwin ? mdl[off] : '0});
            if (!inwin) n_oob++;
            set_rd(la(off), md);
         end
         if ($urandom_range(0, 1) == 1) begin
            off = pick_off();
            md = 16'($urandom);
            d = rand_line();
            inwin = (off >= 0 && off < 1024);
            wr_exp.push_back(rsp_t'{t: cyc + 2, md: md, dat: '0});
            if (inwin) mdl[off] = d;
            else n_oob++;
            set_wr(la(off), d, md);
         end
         step(1);
      end
      clr();
      step(5);
      nr = rd_exp.size();
      nw = wr_exp.size();
      chk("rand rd rsp count", rd_log.size(), nr);
      chk("rand wr ack count", wr_log.size(), nw);
      for (int i = 0; i < nr && i < rd_log.size(); i++) begin
         chk($sformatf("rand rd%0d cycle", i), rd_log[i].t, rd_exp[i].t);
         chk($sformatf("rand rd%0d mdata", i), rd_log[i].md, rd_exp[i].md);
         chk($sformatf("rand rd%0d data", i), rd_log[i].dat, rd_exp[i].dat);
      end
      for (int i = 0; i < nw && i < wr_log.size(); i++) begin
         chk($sformatf("rand wr%0d cycle", i), wr_log[i].t, wr_exp[i].t);
         chk($sformatf("rand wr%0d mdata", i), wr_log[i].md, wr_exp[i].md);
      end
      chk("rand rd_count", rd_count, nr);
      chk("rand wr_count", wr_count, nw);
      chk("rand oob_count", oob_count, n_oob);
      chk("rand ovf_err", ovf_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
